// File: rtl/xmega_regs_pipe.sv
// Register file for the xmega core: REG_COUNT byte registers, two byte/word read ports,
// one byte/word write port, a post-reset/on-request clear sweep, optional bypass and output registers.
module xmega_regs_pipe #(
    parameter int REG_COUNT          = 32,
    parameter int DATA_W             = 8,
    parameter int REGISTERED_OUTPUTS = 0,
    parameter int BYPASS             = 1,
    parameter int AW                 = $clog2(REG_COUNT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                ready,
    input  logic [AW-1:0]       rs1a,
    input  logic                rs1m,
    output logic [2*DATA_W-1:0] rs1,
    input  logic [AW-1:0]       rs2a,
    input  logic                rs2m,
    output logic [2*DATA_W-1:0] rs2,
    input  logic [AW-1:0]       rda,
    input  logic [2*DATA_W-1:0] rd,
    input  logic                rdw,
    input  logic                rdm
);

    localparam int            PW   = AW - 1;
    localparam logic [PW-1:0] LAST = PW'(REG_COUNT / 2 - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_d;
    logic [PW-1:0]       cnt, cnt_d;
    logic [DATA_W-1:0]   mem  [REG_COUNT];
    logic [DATA_W-1:0]   view [REG_COUNT];

    logic                wr_en, wr_hi_en;
    logic [AW-1:0]       wr_lo_idx, wr_hi_idx;
    logic [AW-1:0]       rd1_lo_idx, rd1_hi_idx, rd2_lo_idx, rd2_hi_idx;
    logic [2*DATA_W-1:0] rd1_val, rd2_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // clr always restarts the sweep from pair 0, even mid-sweep.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            CLEAR: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + PW'(1);
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready     = (state == RUN);
    assign wr_en     = ready & rdw;
    assign wr_hi_en  = wr_en & rdm;
    assign wr_lo_idx = rdm ? {rda[AW-2:0], 1'b0} : rda;
    assign wr_hi_idx = {rda[AW-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[{cnt, 1'b0}] <= '0;
            mem[{cnt, 1'b1}] <= '0;
        end else if (wr_en) begin
            mem[wr_lo_idx] <= rd[DATA_W-1:0];
            if (rdm) begin
                mem[wr_hi_idx] <= rd[2*DATA_W-1:DATA_W];
            end
        end
    end

    // Per-byte forwarding view: each register is individually overridden by the byte
    // being written to it this cycle, so partial word overlaps forward only one half.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            view[i] = mem[i];
            if (BYPASS != 0) begin
                if (wr_en && wr_lo_idx == AW'(i)) begin
                    view[i] = rd[DATA_W-1:0];
                end else if (wr_hi_en && wr_hi_idx == AW'(i)) begin
                    view[i] = rd[2*DATA_W-1:DATA_W];
                end
            end
        end
    end

    assign rd1_lo_idx = rs1m ? {rs1a[AW-2:0], 1'b0} : rs1a;
    assign rd1_hi_idx = {rs1a[AW-2:0], 1'b1};
    assign rd2_lo_idx = rs2m ? {rs2a[AW-2:0], 1'b0} : rs2a;
    assign rd2_hi_idx = {rs2a[AW-2:0], 1'b1};

    assign rd1_val = ready ? {(rs1m ? view[rd1_hi_idx] : {DATA_W{1'b0}}), view[rd1_lo_idx]}
                           : '0;
    assign rd2_val = ready ? {(rs2m ? view[rd2_hi_idx] : {DATA_W{1'b0}}), view[rd2_lo_idx]}
                           : '0;

    generate
        if (REGISTERED_OUTPUTS != 0) begin : g_reg
            logic [2*DATA_W-1:0] rs1_q, rs2_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rs1_q <= '0;
                    rs2_q <= '0;
                end else begin
                    rs1_q <= rd1_val;
                    rs2_q <= rd2_val;
                end
            end

            // Gate with ready so a value sampled in the clr cycle never leaks into the sweep.
            assign rs1 = ready ? rs1_q : '0;
            assign rs2 = ready ? rs2_q : '0;
        end else begin : g_comb
            assign rs1 = rd1_val;
            assign rs2 = rd2_val;
        end
    endgenerate

endmodule
